hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 46 ++++
 rtl/hazard_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-side signals between the hazard controller and the datapath.
// The datapath (master) drives operand/control observations; the controller (slave) drives enables.
interface hazard_ctrl_if;
  logic [4:0]  IFID_RS1;
  logic [4:0]  IFID_RS2;
  logic        IFID_UsesRs2;
  logic        ID_Branch;
  logic [4:0]  IDEX_RD;
  logic        IDEX_RegWrite;
  logic        IDEX_MemRead;
  logic [4:0]  EXMEM_RD;
  logic        EXMEM_MemRead;
  logic        BR_Taken;
  logic        ICACHE_stall;
  logic        DCACHE_stall;
  logic        CNT_clr;

  logic        PC_write;
  logic        IFID_write;
  logic        IDEX_write;
  logic        EXMEM_write;
  logic        MEMWB_write;
  logic        IFID_flush;
  logic        IDEX_bubble;
  logic [15:0] STALL_CNT;
  logic [15:0] FREEZE_CNT;
  logic [15:0] FLUSH_CNT;

  modport master (
    output IFID_RS1, IFID_RS2, IFID_UsesRs2, ID_Branch,
           IDEX_RD, IDEX_RegWrite, IDEX_MemRead,
           EXMEM_RD, EXMEM_MemRead, BR_Taken,
           ICACHE_stall, DCACHE_stall, CNT_clr,
    input  PC_write, IFID_write, IDEX_write, EXMEM_write, MEMWB_write,
           IFID_flush, IDEX_bubble, STALL_CNT, FREEZE_CNT, FLUSH_CNT
  );

  modport slave (
    input  IFID_RS1, IFID_RS2, IFID_UsesRs2, ID_Branch,
           IDEX_RD, IDEX_RegWrite, IDEX_MemRead,
           EXMEM_RD, EXMEM_MemRead, BR_Taken,
           ICACHE_stall, DCACHE_stall, CNT_clr,
    output PC_write, IFID_write, IDEX_write, EXMEM_write, MEMWB_write,
           IFID_flush, IDEX_bubble, STALL_CNT, FREEZE_CNT, FLUSH_CNT
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use/branch-operand stalls, cache freezes,
// branch redirect flushes (remembered across freezes) and saturating event counters.
module hazard_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, FREEZE} state_e;

  state_e      state_q, state_d;
  logic        flush_pend_q, flush_pend_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] freeze_cnt_q, freeze_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic mem_stall;
  logic idex_match, exmem_match;
  logic haz_a, haz_b, haz_c, haz;
  logic flush_eff;
  logic pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic ifid_flush, idex_bubble;
  logic stall_cycle;

  function automatic logic [15:0] satInc(input logic [15:0] cnt, input logic en);
    return (en && (cnt != 16'hFFFF)) ? cnt + 16'd1 : cnt;
  endfunction

  // x0 is excluded by requiring a nonzero destination before any source compare.
  assign idex_match  = (hz.IDEX_RD != 5'd0) &&
                       ((hz.IDEX_RD == hz.IFID_RS1) ||
                        (hz.IFID_UsesRs2 && (hz.IDEX_RD == hz.IFID_RS2)));
  assign exmem_match = (hz.EXMEM_RD != 5'd0) &&
                       ((hz.EXMEM_RD == hz.IFID_RS1) ||
                        (hz.IFID_UsesRs2 && (hz.EXMEM_RD == hz.IFID_RS2)));

  assign mem_stall = hz.ICACHE_stall | hz.DCACHE_stall;
  assign haz_a     = hz.IDEX_MemRead & idex_match;
  assign haz_b     = hz.ID_Branch & hz.IDEX_RegWrite & idex_match;
  assign haz_c     = hz.ID_Branch & hz.EXMEM_MemRead & exmem_match;
  assign haz       = haz_a | haz_b | haz_c;
  assign flush_eff = hz.BR_Taken | flush_pend_q;

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    memwb_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    stall_cycle  = 1'b0;

    case (state_q)
      RUN:     if (mem_stall)  state_d = FREEZE;
      FREEZE:  if (!mem_stall) state_d = RUN;
      default: state_d = RUN;
    endcase

    // Freeze beats hazards and redirects; a redirect seen mid-freeze is parked in flush_pend.
    if (mem_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      if (hz.BR_Taken) flush_pend_d = 1'b1;
    end else if (haz) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      stall_cycle = 1'b1;
    end else begin
      flush_pend_d = 1'b0;
      ifid_flush   = flush_eff;
    end

    if (hz.CNT_clr) begin
      stall_cnt_d  = 16'd0;
      freeze_cnt_d = 16'd0;
      flush_cnt_d  = 16'd0;
    end else begin
      stall_cnt_d  = satInc(stall_cnt_q, stall_cycle);
      freeze_cnt_d = satInc(freeze_cnt_q, mem_stall);
      flush_cnt_d  = satInc(flush_cnt_q, ifid_flush);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      flush_pend_q <= 1'b0;
      stall_cnt_q  <= 16'd0;
      freeze_cnt_q <= 16'd0;
      flush_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      stall_cnt_q  <= stall_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // While in reset the pipeline is left free-running with no flush or bubble.
  assign hz.PC_write    = pc_write    | ~rst_n;
  assign hz.IFID_write  = ifid_write  | ~rst_n;
  assign hz.IDEX_write  = idex_write  | ~rst_n;
  assign hz.EXMEM_write = exmem_write | ~rst_n;
  assign hz.MEMWB_write = memwb_write | ~rst_n;
  assign hz.IFID_flush  = ifid_flush  & rst_n;
  assign hz.IDEX_bubble = idex_bubble & rst_n;
  assign hz.STALL_CNT   = stall_cnt_q;
  assign hz.FREEZE_CNT  = freeze_cnt_q;
  assign hz.FLUSH_CNT   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: stalls, freezes, pending flushes,
// counter saturation/clear and asynchronous reset, all against hand-computed values.
module tb_hazard_ctrl;
  logic clk;
  logic rst_n;
  int   testCount;
  int   failCount;

  hazard_ctrl_if hz ();

  hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.slave)
  );

  logic [4:0] writes;
  assign writes = {hz.PC_write, hz.IFID_write, hz.IDEX_write, hz.EXMEM_write, hz.MEMWB_write};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses2,
                               input logic branch, input logic [4:0] idexRd, input logic idexRegWrite,
                               input logic idexMemRead, input logic [4:0] exmemRd,
                               input logic exmemMemRead, input logic brTaken,
                               input logic icache, input logic dcache);
    hz.IFID_RS1      = rs1;
    hz.IFID_RS2      = rs2;
    hz.IFID_UsesRs2  = uses2;
    hz.ID_Branch     = branch;
    hz.IDEX_RD       = idexRd;
    hz.IDEX_RegWrite = idexRegWrite;
    hz.IDEX_MemRead  = idexMemRead;
    hz.EXMEM_RD      = exmemRd;
    hz.EXMEM_MemRead = exmemMemRead;
    hz.BR_Taken      = brTaken;
    hz.ICACHE_stall  = icache;
    hz.DCACHE_stall  = dcache;
    #1;
  endtask

  task automatic idle();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearCounters();
    idle();
    hz.CNT_clr = 1'b1;
    tick();
    hz.CNT_clr = 1'b0;
  endtask

  task automatic checkCtrl(input string tag, input logic [4:0] expWrites,
                           input logic expFlush, input logic expBubble);
    checkOutput({tag, ".writes"}, 32'(writes), 32'(expWrites));
    checkOutput({tag, ".flush"}, 32'(hz.IFID_flush), 32'(expFlush));
    checkOutput({tag, ".bubble"}, 32'(hz.IDEX_bubble), 32'(expBubble));
  endtask

  initial begin
    testCount  = 0;
    failCount  = 0;
    hz.CNT_clr = 1'b0;
    rst_n      = 1'b0;

    // Reset with a freeze, hazard and redirect all requested: outputs must still be free-running.
    applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkCtrl("reset", 5'b11111, 1'b0, 1'b0);
    tick();
    checkOutput("reset.stallCnt", 32'(hz.STALL_CNT), 32'd0);
    checkOutput("reset.freezeCnt", 32'(hz.FREEZE_CNT), 32'd0);
    checkOutput("reset.flushCnt", 32'(hz.FLUSH_CNT), 32'd0);
    idle();
    rst_n = 1'b1;
    checkCtrl("idle", 5'b11111, 1'b0, 1'b0);
    tick();

    // Load-use on rs1.
    applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCtrl("loadUse", 5'b00111, 1'b0, 1'b1);
    tick();
    idle();
    checkCtrl("loadUseDone", 5'b11111, 1'b0, 1'b0);
    checkOutput("loadUse.stallCnt", 32'(hz.STALL_CNT), 32'd1);
    clearCounters();
    checkOutput("clr.stallCnt", 32'(hz.STALL_CNT), 32'd0);

    // Load feeding a branch: EX-stage stall, then MEM-stage stall.
    applyStimulus(5'd0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCtrl("ldBr.ex", 5'b00111, 1'b0, 1'b1);
    tick();
    applyStimulus(5'd0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    checkCtrl("ldBr.mem", 5'b00111, 1'b0, 1'b1);
    tick();
    applyStimulus(5'd0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCtrl("ldBr.go", 5'b11111, 1'b0, 1'b0);
    checkOutput("ldBr.stallCnt", 32'(hz.STALL_CNT), 32'd2);
    tick();

    // rs2 match ignored when rs2 is unused.
    applyStimulus(5'd0, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCtrl("rs2Unused", 5'b11111, 1'b0, 1'b0);
    tick();
    // ALU result feeding a branch stalls; feeding a non-branch does not.
    applyStimulus(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCtrl("aluBr", 5'b00111, 1'b0, 1'b1);
    tick();
    applyStimulus(5'd3, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCtrl("aluNoBr", 5'b11111, 1'b0, 1'b0);
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCtrl("x0", 5'b11111, 1'b0, 1'b0);
    tick();
    checkOutput("x0.stallCnt", 32'(hz.STALL_CNT), 32'd3);

    clearCounters();
    // Plain redirect, then a redirect masked by a hazard.
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkCtrl("taken", 5'b11111, 1'b1, 1'b0);
    tick();
    applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkCtrl("takenHaz", 5'b00111, 1'b0, 1'b1);
    tick();
    checkOutput("taken.flushCnt", 32'(hz.FLUSH_CNT), 32'd1);
    checkOutput("taken.stallCnt", 32'(hz.STALL_CNT), 32'd1);

    clearCounters();
    // Redirect during a 3-cycle D-cache freeze comes out as one flush afterwards.
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkCtrl("frz1", 5'b00000, 1'b0, 1'b0);
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkCtrl("frz2", 5'b00000, 1'b0, 1'b0);
    tick();
    checkCtrl("frz3", 5'b00000, 1'b0, 1'b0);
    tick();
    idle();
    checkCtrl("frzFlush", 5'b11111, 1'b1, 1'b0);
    checkOutput("frz.freezeCnt", 32'(hz.FREEZE_CNT), 32'd3);
    tick();
    checkCtrl("frzAfter", 5'b11111, 1'b0, 1'b0);
    tick();
    checkOutput("frz.flushCnt", 32'(hz.FLUSH_CNT), 32'd1);
    checkOutput("frz.freezeCnt2", 32'(hz.FREEZE_CNT), 32'd3);

    // Freeze outranks hazard and redirect; the redirect is then replayed.
    applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkCtrl("prio", 5'b00000, 1'b0, 1'b0);
    tick();
    idle();
    checkCtrl("prioReplay", 5'b11111, 1'b1, 1'b0);
    tick();

    // Saturation: 65535 load-use stalls, one more, then clear under a live stall.
    clearCounters();
    applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (65535) tick();
    checkOutput("sat.full", 32'(hz.STALL_CNT), 32'hFFFF);
    tick();
    checkOutput("sat.hold", 32'(hz.STALL_CNT), 32'hFFFF);
    hz.CNT_clr = 1'b1;
    tick();
    hz.CNT_clr = 1'b0;
    checkOutput("sat.clr", 32'(hz.STALL_CNT), 32'd0);
    tick();
    checkOutput("sat.restart", 32'(hz.STALL_CNT), 32'd1);

    // Reset in the middle of a freeze with a parked redirect.
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("midRst.freezeCnt", 32'(hz.FREEZE_CNT), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkCtrl("midRst", 5'b11111, 1'b0, 1'b0);
    checkOutput("midRst.stallCnt", 32'(hz.STALL_CNT), 32'd0);
    checkOutput("midRst.freezeCnt0", 32'(hz.FREEZE_CNT), 32'd0);
    idle();
    tick();
    rst_n = 1'b1;
    #1;
    checkCtrl("postRst", 5'b11111, 1'b0, 1'b0);
    tick();
    checkOutput("postRst.flushCnt", 32'(hz.FLUSH_CNT), 32'd0);
    checkOutput("postRst.freezeCnt", 32'(hz.FREEZE_CNT), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
